spu_decode: RTL and testbench
=============================

Name: spu_decode

Overview:
- Instruction decode stage directly upstream of the SPU execution pipes; consumes 32-bit fetched instruction words.
- Buffers incoming words in a small FIFO and decodes RI16-format immediate loads (ILH, ILHU) using the shared `Opcodes` enum.
- Presents one registered decoded bundle per cycle to the issue/execute stage over a valid/ready handshake.
- Steers each bundle to an execution pipe (`NUM_PIPES`) and flags unsupported encodings as illegal.

Parameters:
- DEPTH, 2, instruction FIFO entries; power of two, >= 2.
- PIPE_W, $clog2(NUM_PIPES), width of the pipe-select field; derived from the package, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered and staged instructions.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  FIFO can accept; equals !full.
- in_instr  in  WORD  raw instruction, bit 31 = SPU bit 0.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_opcode  out  11  `Opcodes` value; 0 when illegal.
- out_rt  out  7  target register, in_instr[6:0].
- out_imm16  out  HALFWORD  immediate, in_instr[22:7].
- out_pipe  out  PIPE_W  execution pipe; 0 = even pipe.
- out_illegal  out  1  encoding not in `Opcodes`.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - FIFO empty; rd/wr pointers 0.
  - out_valid=0, out_opcode=0, out_rt=0, out_imm16=0, out_pipe=0, out_illegal=0.
  - in_ready=1 from the first cycle after reset deasserts.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop when entry present && (!out_valid || out_ready).
  - Push and pop in the same cycle are legal even when full; in_ready stays combinational on full only, with no out_ready path.
  - Pointers carry an extra wrap bit: full = MSBs differ and LSBs equal; empty = pointers equal.
- Decode is combinational on the FIFO head:
  - Key = {2'b00, head[31:23]}.
  - Match IMMEDIATE_LOAD_HALFWORD or IMMEDIATE_LOAD_HALFWORD_UPPER: opcode = key, pipe = 0, illegal = 0.
  - Otherwise: opcode = 0, pipe = 0, illegal = 1.
  - rt and imm16 are extracted unconditionally.
- Output register:
  - Loads on pop.
  - out_valid goes 1 on pop, goes 0 on out_ready without a pop, and holds when out_ready=0.
  - All out_* fields are stable while out_valid && !out_ready.
- Latency:
  - Word accepted in cycle N, with FIFO empty and output free, appears with out_valid=1 in cycle N+1.
  - Throughput is 1 per cycle under continuous out_ready.
- Backpressure: with out_ready=0, the FIFO fills after DEPTH further accepts, then in_ready=0.
- Flush:
  - Synchronous. Next cycle: FIFO empty, out_valid=0.
  - A push or pop coinciding with flush is dropped; flush has priority.
  - in_ready remains driven as !full during the flush cycle.
- Illegal bundles travel like any other; downstream decides on trap. No stall.

Optional Feature:
- Macro: SPU_DECODE_STATS_EN.
- Defined:
  - Adds outputs stat_decoded (32) and stat_illegal (32).
  - Both are saturating counters, reset to 0 and not cleared by flush.
  - Each increments by 1 when out_valid && out_ready; stat_illegal additionally requires out_illegal.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Add to defines_pkg:
  - constants OP_FIELD_HI=31, OP_FIELD_LO=23, IMM16_HI=22, IMM16_LO=7, RT_W=7, PIPE_EVEN=0, PIPE_ODD=1.
  - a packed struct decoded_instr_t {opcode, rt, imm16, pipe, illegal}.
- Sub-module spu_instr_fifo (parameterised DEPTH/WIDTH, sync, async reset, flush). Decode logic stays in the top.

Test Plan:
- Reset mid-traffic: assert rst_n=0 with FIFO holding 2 words -> all outputs 0 immediately, in_ready=1 after release, no stale bundle emitted.
- ILH decode: in_instr=0x41891A05, out_ready=1 -> next cycle out_valid=1, out_opcode=11'b00010000011, out_rt=5, out_imm16=0x1234, out_pipe=0, out_illegal=0.
- ILHU boundary fields: in_instr=0x417FFFFF -> out_opcode=11'b00010000010, out_rt=127, out_imm16=0xFFFF.
- Illegal: in_instr=0x00000000 -> out_illegal=1, out_opcode=0, out_rt=0, out_imm16=0; following ILH still decodes correctly.
- Backpressure/full: out_ready=0, push 4 words -> first in out register, DEPTH=2 in FIFO, in_ready=0 on the 4th. Release out_ready -> all emitted in order, one per cycle, none lost or duplicated.
- Flush with simultaneous push and full pipeline: flush=1, in_valid=1 -> next cycle out_valid=0, FIFO empty, flushed word never appears. With SPU_DECODE_STATS_EN, counters are unchanged by the flush.

Source files
------------

// File: rtl/defines_pkg.sv
// -----------------------------------------------------------------------------
// defines_pkg
// Shared definitions for the SPU decode stage:
//   - word / halfword widths and the instruction field positions
//   - the Opcodes enum (11-bit opcode space, RI16 immediate loads)
//   - execution pipe encoding and the registered decoded bundle struct
// -----------------------------------------------------------------------------
package defines_pkg;

  localparam int WORD      = 32;
  localparam int HALFWORD  = 16;
  localparam int OPCODE_W  = 11;
  localparam int NUM_PIPES = 2;
  localparam int PIPE_W    = $clog2(NUM_PIPES);

  // Field positions use the Verilog bit order of the fetched word, where
  // bit 31 is SPU bit 0.
  localparam int OP_FIELD_HI = 31;
  localparam int OP_FIELD_LO = 23;
  localparam int IMM16_HI    = 22;
  localparam int IMM16_LO    = 7;
  localparam int RT_W        = 7;

  localparam int PIPE_EVEN = 0;
  localparam int PIPE_ODD  = 1;

  // RI16 opcodes are 9 bits wide; they sit zero-extended in the 11-bit space.
  typedef enum logic [OPCODE_W-1:0] {
    IMMEDIATE_LOAD_HALFWORD_UPPER = 11'b000_1000_0010,
    IMMEDIATE_LOAD_HALFWORD       = 11'b000_1000_0011
  } Opcodes;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [RT_W-1:0]     rt;
    logic [HALFWORD-1:0] imm16;
    logic [PIPE_W-1:0]   pipe;
    logic                illegal;
  } decoded_instr_t;

endpackage

// File: rtl/spu_instr_fifo.sv
// -----------------------------------------------------------------------------
// spu_instr_fifo
// Synchronous instruction FIFO with wrap-bit pointers and a synchronous flush.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          empties the FIFO next cycle; drops a coincident push/pop
//   push, wdata    write request and data (ignored when full unless popping)
//   pop            read request (ignored when empty)
//   rdata          head entry (valid when !empty)
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module spu_instr_fifo
  import defines_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so push-while-full is fine then.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments so both pointers update from the
      // pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // meaningful, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/spu_decode.sv
// -----------------------------------------------------------------------------
// spu_decode
// Decode stage ahead of the SPU execution pipes. Fetched words are buffered in
// a small FIFO; the head is decoded combinationally (RI16 ILH / ILHU) and
// loaded into a registered bundle presented over valid/ready.
// When the FIFO is empty and the output register is free, an incoming word is
// decoded straight into the output register, giving one-cycle latency.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             drop all buffered and staged instructions
//   in_valid/in_ready fetch handshake (in_ready = !full)
//   in_instr          raw instruction word
//   out_valid/out_ready  issue handshake
//   out_opcode, out_rt, out_imm16, out_pipe, out_illegal  decoded bundle
// Optional (macro SPU_DECODE_STATS_EN):
//   stat_decoded, stat_illegal  saturating transfer counters
// -----------------------------------------------------------------------------
module spu_decode
  import defines_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD-1:0]     in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [RT_W-1:0]     out_rt,
  output logic [HALFWORD-1:0] out_imm16,
  output logic [PIPE_W-1:0]   out_pipe,
  output logic                out_illegal
`ifdef SPU_DECODE_STATS_EN
  ,
  output logic [31:0]         stat_decoded,
  output logic [31:0]         stat_illegal
`endif
);

  logic            fifo_full;
  logic            fifo_empty;
  logic [WORD-1:0] fifo_head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            accept;
  logic            take;
  logic            load;
  logic [WORD-1:0] src_word;
  logic [OPCODE_W-1:0] key;
  decoded_instr_t  dec;
  decoded_instr_t  out_q;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  // Output register can take a new bundle when empty or being drained.
  assign take     = !out_valid || out_ready;

  // Words bypass the FIFO only when it is empty, so order is preserved.
  assign fifo_push = accept && !(fifo_empty && take);
  assign fifo_pop  = take && !fifo_empty;
  assign load      = take && (!fifo_empty || accept) && !flush;
  assign src_word  = fifo_empty ? in_instr : fifo_head;

  spu_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .wdata (in_instr),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key = {2'b00, src_word[OP_FIELD_HI:OP_FIELD_LO]};

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    dec         = '0;
    dec.rt      = src_word[RT_W-1:0];
    dec.imm16   = src_word[IMM16_HI:IMM16_LO];
    dec.pipe    = PIPE_W'(PIPE_EVEN);
    dec.illegal = 1'b1;
    if (key == IMMEDIATE_LOAD_HALFWORD || key == IMMEDIATE_LOAD_HALFWORD_UPPER) begin
      dec.opcode  = key;
      dec.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opcode  = out_q.opcode;
  assign out_rt      = out_q.rt;
  assign out_imm16   = out_q.imm16;
  assign out_pipe    = out_q.pipe;
  assign out_illegal = out_q.illegal;

`ifdef SPU_DECODE_STATS_EN
  logic fire;
  assign fire = out_valid && out_ready;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else begin
      if (fire && (stat_decoded != '1)) stat_decoded <= stat_decoded + 1'b1;
      if (fire && out_q.illegal && (stat_illegal != '1)) stat_illegal <= stat_illegal + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spu_decode.sv
// -----------------------------------------------------------------------------
// tb_spu_decode
// Directed, self-checking bench for spu_decode (DEPTH = 2). Inputs change one
// time unit after the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_spu_decode;
  import defines_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WORD-1:0]     in_instr;
  logic                out_valid;
  logic                out_ready;
  logic [OPCODE_W-1:0] out_opcode;
  logic [RT_W-1:0]     out_rt;
  logic [HALFWORD-1:0] out_imm16;
  logic [PIPE_W-1:0]   out_pipe;
  logic                out_illegal;
`ifdef SPU_DECODE_STATS_EN
  logic [31:0]         stat_decoded;
  logic [31:0]         stat_illegal;
`endif

  int errors = 0;
  int checks = 0;

  spu_decode #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rt      (out_rt),
    .out_imm16   (out_imm16),
    .out_pipe    (out_pipe),
    .out_illegal (out_illegal)
`ifdef SPU_DECODE_STATS_EN
    ,
    .stat_decoded (stat_decoded),
    .stat_illegal (stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input logic valid, input logic [10:0] opcode,
                              input logic [6:0] rt, input logic [15:0] imm16,
                              input logic pipe, input logic illegal);
    check({tag, "_valid"},   32'(out_valid),   32'(valid));
    check({tag, "_opcode"},  32'(out_opcode),  32'(opcode));
    check({tag, "_rt"},      32'(out_rt),      32'(rt));
    check({tag, "_imm16"},   32'(out_imm16),   32'(imm16));
    check({tag, "_pipe"},    32'(out_pipe),    32'(pipe));
    check({tag, "_illegal"}, 32'(out_illegal), 32'(illegal));
  endtask

  task automatic check_stats(input string tag, input int dec_n, input int ill_n);
`ifdef SPU_DECODE_STATS_EN
    check({tag, "_stat_decoded"}, stat_decoded, 32'(dec_n));
    check({tag, "_stat_illegal"}, stat_illegal, 32'(ill_n));
`else
    if (tag.len() < 0 || dec_n < 0 || ill_n < 0) $display("unexpected stats arguments");
`endif
  endtask

  localparam logic [10:0] OP_ILH  = 11'b00010000011;
  localparam logic [10:0] OP_ILHU = 11'b00010000010;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check_bundle("reset", 1'b0, 11'd0, 7'd0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check_stats("reset", 0, 0);

    // ---------------- decode, continuous out_ready ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h41891A05;
    tick();
    check_bundle("ilh", 1'b1, OP_ILH, 7'd5, 16'h1234, 1'b0, 1'b0);

    in_instr = 32'h417FFFFF;
    tick();
    check_bundle("ilhu_max", 1'b1, OP_ILHU, 7'd127, 16'hFFFF, 1'b0, 1'b0);

    in_instr = 32'h00000000;
    tick();
    check_bundle("illegal", 1'b1, 11'd0, 7'd0, 16'h0000, 1'b0, 1'b1);

    in_instr = 32'h41891A05;
    tick();
    check_bundle("ilh_after_illegal", 1'b1, OP_ILH, 7'd5, 16'h1234, 1'b0, 1'b0);

    in_valid = 1'b0;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check_stats("after_decode", 4, 1);

    // ---------------- backpressure / full ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h41000001;              // ILHU rt=1
    check("bp_ready_a", 32'(in_ready), 32'd1);
    tick();
    check_bundle("bp_a", 1'b1, OP_ILHU, 7'd1, 16'h0000, 1'b0, 1'b0);

    in_instr = 32'h41800002;               // ILH rt=2
    tick();
    check("bp_ready_after_b", 32'(in_ready), 32'd1);
    check("bp_hold_rt_b", 32'(out_rt), 32'd1);

    in_instr = 32'h00000003;               // illegal rt=3
    tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);

    in_instr = 32'h41000004;               // refused while full
    tick();
    check("bp_full_ready_d", 32'(in_ready), 32'd0);
    check_bundle("bp_hold_a", 1'b1, OP_ILHU, 7'd1, 16'h0000, 1'b0, 1'b0);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_bundle("bp_b", 1'b1, OP_ILH, 7'd2, 16'h0000, 1'b0, 1'b0);
    tick();
    check_bundle("bp_c", 1'b1, 11'd0, 7'd3, 16'h0000, 1'b0, 1'b1);
    tick();
    check("bp_no_d_valid", 32'(out_valid), 32'd0);
    check("bp_ready_drained", 32'(in_ready), 32'd1);
    check_stats("after_bp", 7, 2);

    // ---------------- flush with simultaneous push ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h41000001;
    tick();
    in_instr  = 32'h41800002;
    tick();
    flush    = 1'b1;
    in_instr = 32'h41800077;
    check("flush_cycle_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check_stats("after_flush", 7, 2);
    out_ready = 1'b1;
    tick();
    check("flush_no_stale_1", 32'(out_valid), 32'd0);
    tick();
    check("flush_no_stale_2", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_instr = 32'h41800011;               // must bypass: FIFO is empty
    tick();
    check_bundle("post_flush", 1'b1, OP_ILH, 7'h11, 16'h0000, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // ---------------- reset mid-traffic ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h41000001;
    tick();
    in_instr  = 32'h41800002;
    tick();
    in_instr  = 32'h41000003;
    tick();
    in_valid  = 1'b0;
    check("mid_full_before_reset", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_bundle("mid_reset", 1'b0, 11'd0, 7'd0, 16'h0000, 1'b0, 1'b0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_reset_no_stale_1", 32'(out_valid), 32'd0);
    tick();
    check("mid_reset_no_stale_2", 32'(out_valid), 32'd0);
    check("mid_reset_ready_after", 32'(in_ready), 32'd1);
    check_stats("after_mid_reset", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
